// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bundle: ID-side inputs, stall/flush controls, EX-side outputs.
// master: upstream/control side driving ID fields; slave: the id_ex_stage register.
interface id_ex_stage_if #(
    parameter int unsigned DataW    = 32,
    parameter int unsigned RegAddrW = 5,
    parameter int unsigned CntW     = 16
);
    logic                stall;
    logic                flush;

    logic                id_valid;
    logic [1:0]          id_alu_op;
    logic [5:0]          id_func_code;
    logic                id_reg_dst;
    logic                id_alu_src;
    logic                id_mem_read;
    logic                id_mem_write;
    logic                id_mem_to_reg;
    logic                id_reg_write;
    logic [DataW-1:0]    id_read_data1;
    logic [DataW-1:0]    id_read_data2;
    logic [DataW-1:0]    id_imm;
    logic [RegAddrW-1:0] id_rs;
    logic [RegAddrW-1:0] id_rt;
    logic [RegAddrW-1:0] id_rd;

    logic                ex_valid;
    logic [1:0]          ex_alu_op;
    logic [5:0]          ex_func_code;
    logic                ex_reg_dst;
    logic                ex_alu_src;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_mem_to_reg;
    logic                ex_reg_write;
    logic [DataW-1:0]    ex_read_data1;
    logic [DataW-1:0]    ex_read_data2;
    logic [DataW-1:0]    ex_imm;
    logic [RegAddrW-1:0] ex_rs;
    logic [RegAddrW-1:0] ex_rt;
    logic [RegAddrW-1:0] ex_rd;

    logic                hazard_stall;
    logic [CntW-1:0]     bubble_count;

    modport master (
        output stall, flush, id_valid, id_alu_op, id_func_code, id_reg_dst, id_alu_src,
               id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_read_data1,
               id_read_data2, id_imm, id_rs, id_rt, id_rd,
        input  ex_valid, ex_alu_op, ex_func_code, ex_reg_dst, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_read_data1, ex_read_data2,
               ex_imm, ex_rs, ex_rt, ex_rd, hazard_stall, bubble_count
    );

    modport slave (
        input  stall, flush, id_valid, id_alu_op, id_func_code, id_reg_dst, id_alu_src,
               id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_read_data1,
               id_read_data2, id_imm, id_rs, id_rt, id_rd,
        output ex_valid, ex_alu_op, ex_func_code, ex_reg_dst, ex_alu_src, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_read_data1, ex_read_data2,
               ex_imm, ex_rs, ex_rt, ex_rd, hazard_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hold (stall), flush (bubble) and a saturating bubble counter.
// Optional load-use hazard detection is enabled by defining HAZARD_DETECT_EN.
module id_ex_stage #(
    parameter int unsigned DataW    = 32,
    parameter int unsigned RegAddrW = 5,
    parameter int unsigned CntW     = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic                valid;
        logic [1:0]          alu_op;
        logic [5:0]          func_code;
        logic                reg_dst;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic [DataW-1:0]    read_data1;
        logic [DataW-1:0]    read_data2;
        logic [DataW-1:0]    imm;
        logic [RegAddrW-1:0] rs;
        logic [RegAddrW-1:0] rt;
        logic [RegAddrW-1:0] rd;
    } ex_regs_t;

    ex_regs_t        ex_q, ex_d, id_ex;
    logic [CntW-1:0] bubble_cnt_q, bubble_cnt_d;
    logic            hazard;

    // ID slot packed as it would land in EX; valid forced high, only used when id_valid.
    assign id_ex = '{
        valid:      1'b1,
        alu_op:     bus.id_alu_op,
        func_code:  bus.id_func_code,
        reg_dst:    bus.id_reg_dst,
        alu_src:    bus.id_alu_src,
        mem_read:   bus.id_mem_read,
        mem_write:  bus.id_mem_write,
        mem_to_reg: bus.id_mem_to_reg,
        reg_write:  bus.id_reg_write,
        read_data1: bus.id_read_data1,
        read_data2: bus.id_read_data2,
        imm:        bus.id_imm,
        rs:         bus.id_rs,
        rt:         bus.id_rt,
        rd:         bus.id_rd
    };

`ifdef HAZARD_DETECT_EN
    // Load in EX whose destination feeds the instruction in ID: insert one bubble.
    assign hazard = ex_q.valid & ex_q.mem_read & bus.id_valid & ~bus.flush &
                    ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));
`else
    assign hazard = 1'b0;
`endif

    // Next-state selection: flush > stall > hazard bubble > load.
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush || (!bus.stall && hazard)) begin
            ex_d = '0;
            if (!(&bubble_cnt_q)) begin
                bubble_cnt_d = bubble_cnt_q + CntW'(1);
            end
        end else if (!bus.stall) begin
            // An empty ID slot becomes a bubble but is not counted.
            ex_d = bus.id_valid ? id_ex : '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_func_code  = ex_q.func_code;
    assign bus.ex_reg_dst    = ex_q.reg_dst;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_read_data1 = ex_q.read_data1;
    assign bus.ex_read_data2 = ex_q.read_data2;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.hazard_stall  = hazard;
    assign bus.bubble_count  = bubble_cnt_q;

endmodule
